// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- iterative signed integer divider (restoring, one bit per cycle)
//
// Divides the signed dividend DivA by the signed divisor DivB. The quotient
// truncates toward zero and the remainder takes the sign of the dividend.
// The core works on unsigned magnitudes and applies the signs in a final
// fix-up cycle. The result registers Hi/Lo are written only in that cycle.
//
// Ports
//   Clk         in   system clock, rising-edge active
//   Reset       in   asynchronous active-low reset
//   DivControl  in   start request, honoured only while idle
//   DivA        in   [WIDTH-1:0] signed dividend
//   DivB        in   [WIDTH-1:0] signed divisor
//   Hi          out  [WIDTH-1:0] remainder
//   Lo          out  [WIDTH-1:0] quotient
//   DivBusy     out  high while the magnitude loop or sign fix-up is running
//   DivDone     out  one-cycle completion pulse
//   DivZero     out  one-cycle pulse alongside DivDone for a zero divisor
//
// Timing for a start accepted at edge T:
//   edges T+1..T+WIDTH  one quotient bit each
//   edge  T+WIDTH+1     signs applied, Hi/Lo written
//   edge  T+WIDTH+2     DivDone registered high for one cycle
//   zero divisor: DONE is entered at T, DivDone/DivZero high after T+1.
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             DivControl,
    input  logic [WIDTH-1:0] DivA,
    input  logic [WIDTH-1:0] DivB,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivBusy,
    output logic             DivDone,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (always < divisor)
    logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic             neg_rem_q, neg_rem_d;
    logic             neg_quo_q, neg_quo_d;
    logic             zero_pend_q, zero_pend_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;

    // Magnitudes. Negating 0x80..0 yields 0x80..0, which read as unsigned is
    // exactly 2^(WIDTH-1), so the most-negative dividend needs no extra bit.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    assign abs_a = DivA[WIDTH-1] ? (~DivA + 1'b1) : DivA;
    assign abs_b = DivB[WIDTH-1] ? (~DivB + 1'b1) : DivB;

    // One restoring step. The shifted remainder can reach 2*divisor-1, so it
    // needs WIDTH+1 bits; the sign of the trial difference decides the bit.
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] trial;
    logic           trial_ok;
    assign rem_shift = {rem_q, quo_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, dvs_q};
    assign trial_ok  = ~trial[WIDTH];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        neg_rem_d   = neg_rem_q;
        neg_quo_d   = neg_quo_q;
        zero_pend_d = zero_pend_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        done_d      = 1'b0;
        zero_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (DivControl) begin
                    if (DivB == '0) begin
                        zero_pend_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        quo_d       = abs_a;
                        dvs_d       = abs_b;
                        rem_d       = '0;
                        count_d     = '0;
                        neg_rem_d   = DivA[WIDTH-1];
                        neg_quo_d   = DivA[WIDTH-1] ^ DivB[WIDTH-1];
                        zero_pend_d = 1'b0;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (trial_ok) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_shift[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q + CW'(1);
                if (count_q == LAST_STEP) begin
                    count_d = '0;
                    state_d = FIX;
                end
            end
            FIX: begin
                lo_d    = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                hi_d    = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
                state_d = DONE;
            end
            default: begin // DONE
                done_d      = 1'b1;
                zero_d      = zero_pend_q;
                zero_pend_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        // Busy tracks the state being entered so it lines up with RUN/FIX.
        busy_d = (state_d == RUN) || (state_d == FIX);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            neg_rem_q   <= 1'b0;
            neg_quo_q   <= 1'b0;
            zero_pend_q <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            neg_rem_q   <= neg_rem_d;
            neg_quo_q   <= neg_quo_d;
            zero_pend_q <= zero_pend_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_q      <= zero_d;
        end
    end

    assign Hi      = hi_q;
    assign Lo      = lo_q;
    assign DivBusy = busy_q;
    assign DivDone = done_q;
    assign DivZero = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- directed self-checking bench for div_unit.
// Inputs change on the falling edge (or 1ns after a rising edge) and outputs
// are sampled on the falling edge. Expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        DivControl = 1'b0;
    logic [31:0] DivA = '0;
    logic [31:0] DivB = '0;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        DivBusy;
    logic        DivDone;
    logic        DivZero;

    int n_cmp = 0;
    int n_bad = 0;

    div_unit #(.WIDTH(32)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .DivControl (DivControl),
        .DivA       (DivA),
        .DivB       (DivB),
        .Hi         (Hi),
        .Lo         (Lo),
        .DivBusy    (DivBusy),
        .DivDone    (DivDone),
        .DivZero    (DivZero)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Start a division (call right after a falling edge), then watch it until
    // DivDone, checking latency, busy length, Hi/Lo hold and the result.
    // inject_at > 0 pulses a new 9/3 request at that falling edge and then
    // scribbles over DivA/DivB, both of which must be ignored.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input bit exp_zero, input int inject_at);
        logic [31:0] snap_hi;
        logic [31:0] snap_lo;
        bit          hold_bad;
        bit          zero_bad;
        int          n;
        int          busy_n;
        snap_hi  = Hi;
        snap_lo  = Lo;
        hold_bad = 1'b0;
        zero_bad = 1'b0;
        n        = 0;
        busy_n   = 0;
        DivControl = 1'b1;
        DivA       = a;
        DivB       = b;
        @(posedge Clk);
        #1 DivControl = 1'b0;
        while (n < 80) begin
            @(negedge Clk);
            n++;
            if (inject_at > 0 && n == inject_at) begin
                DivControl = 1'b1;
                DivA       = 32'd9;
                DivB       = 32'd3;
            end else if (inject_at > 0 && n == inject_at + 1) begin
                DivControl = 1'b0;
                DivA       = 32'd123;
                DivB       = 32'd0;
            end
            if (DivBusy) begin
                busy_n++;
                if (Hi !== snap_hi || Lo !== snap_lo) hold_bad = 1'b1;
            end
            if (DivZero && !DivDone) zero_bad = 1'b1;
            if (DivDone) break;
        end
        $display("xact %s: A=0x%08h B=0x%08h -> Lo=0x%08h Hi=0x%08h zero=%0b after %0d cycles",
                 tag, a, b, Lo, Hi, DivZero, n);
        chk({tag, ".latency"}, 32'(n), exp_zero ? 32'd2 : 32'd35);
        chk({tag, ".busy_cycles"}, 32'(busy_n), exp_zero ? 32'd0 : 32'd33);
        chk({tag, ".hold_in_run"}, 32'(hold_bad), 32'd0);
        chk({tag, ".zero_without_done"}, 32'(zero_bad), 32'd0);
        chk({tag, ".lo"}, Lo, exp_lo);
        chk({tag, ".hi"}, Hi, exp_hi);
        chk({tag, ".divzero"}, 32'(DivZero), 32'(exp_zero));
    endtask

    task automatic done_low(input string tag);
        @(negedge Clk);
        chk({tag, ".done_pulse_end"}, 32'(DivDone), 32'd0);
        chk({tag, ".zero_pulse_end"}, 32'(DivZero), 32'd0);
    endtask

    initial begin
        int done_cnt;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("reset.hi", Hi, 32'd0);
        chk("reset.lo", Lo, 32'd0);
        chk("reset.busy", 32'(DivBusy), 32'd0);
        chk("reset.done", 32'(DivDone), 32'd0);
        chk("reset.zero", 32'(DivZero), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);

        run_div("7/2", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 0);
        done_low("7/2");
        run_div("-7/2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 0);
        run_div("7/-2", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 0);
        run_div("-7/-2", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0, 0);
        run_div("min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 0);
        run_div("min/2", 32'h8000_0000, 32'd2, 32'hC000_0000, 32'd0, 1'b0, 0);
        run_div("0/5", 32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 0);
        // 1105 / 32 = 34 rem 17 leaves Hi=0x11, Lo=0x22 for the zero test
        run_div("1105/32", 32'h0000_0451, 32'h0000_0020, 32'h22, 32'h11, 1'b0, 0);
        run_div("5/0", 32'd5, 32'd0, 32'h22, 32'h11, 1'b1, 0);
        done_low("5/0");

        // Start ignored mid-run, operand changes ignored, then back-to-back
        run_div("100/7_inject", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 9);
        run_div("9/3_b2b", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 0);
        done_low("9/3_b2b");

        // Reset mid-run
        DivControl = 1'b1;
        DivA       = 32'd100;
        DivB       = 32'd7;
        @(posedge Clk);
        #1 DivControl = 1'b0;
        repeat (14) @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        chk("midreset.lo", Lo, 32'd0);
        chk("midreset.hi", Hi, 32'd0);
        chk("midreset.busy", 32'(DivBusy), 32'd0);
        chk("midreset.done", 32'(DivDone), 32'd0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge Clk);
            if (DivDone) done_cnt++;
        end
        Reset = 1'b1;
        repeat (40) begin
            @(negedge Clk);
            if (DivDone || DivBusy) done_cnt++;
        end
        $display("xact midreset: activity after abort = %0d", done_cnt);
        chk("midreset.no_activity", 32'(done_cnt), 32'd0);
        chk("midreset.lo_after", Lo, 32'd0);
        run_div("20/6", 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 0);
        done_low("20/6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits; all scenarios below use 32.
REQ-002 SHALL have port: Clk  in  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  in  1  asynchronous, active-low reset (Reset=0 resets immediately, independent of Clk).
REQ-004 SHALL have port: DivControl  in  1  start request, sampled on rising edge.
REQ-005 SHALL have port: DivA  in  WIDTH  signed dividend (from register A).
REQ-006 SHALL have port: DivB  in  WIDTH  signed divisor (from register B).
REQ-007 SHALL have port: Hi  out  WIDTH  remainder register.
REQ-008 SHALL have port: Lo  out  WIDTH  quotient register.
REQ-009 SHALL have port: DivBusy  out  1  high while a division is in progress.
REQ-010 SHALL have port: DivDone  out  1  one-cycle pulse when the operation completes.
REQ-011 SHALL have port: DivZero  out  1  one-cycle pulse, coincident with DivDone, when the divisor is zero.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, FIX, DONE; DivBusy=1 in RUN and FIX only.
REQ-013 IDLE with DivControl=1 and DivB!=0 at edge T SHALL latch |DivA|, |DivB|, sign(DivA), sign(DivA) xor sign(DivB), clear partial remainder, load counter=0, go to RUN.
REQ-014 IDLE with DivControl=1 and DivB=0 at edge T SHALL go to DONE with DivZero flagged; Hi/Lo SHALL keep prior values.
REQ-015 RUN SHALL perform one restoring shift-subtract step per cycle on unsigned magnitudes for exactly WIDTH cycles (edges T+1..T+32), then go to FIX.
REQ-016 FIX (edge T+33) SHALL apply signs: Lo = quotient negated if sign bits differ; Hi = remainder negated if dividend negative; go to DONE.
REQ-017 Quotient SHALL truncate toward zero; remainder SHALL take sign of dividend; |Hi| < |DivB|.
REQ-018 Magnitude of the most-negative value (0x80000000) SHALL be handled as unsigned 2^31 (WIDTH+1-bit internal datapath or equivalent); 0x80000000 / 0xFFFFFFFF SHALL give Lo=0x80000000 (wrap), Hi=0, no flag.
REQ-019 DONE SHALL assert DivDone=1 for exactly one cycle (cycle following edge T+34 for normal ops, T+1 for divide-by-zero) and return to IDLE on next edge.
REQ-020 Hi and Lo SHALL change only at the FIX edge; they SHALL hold stable at all other times, including throughout RUN.
REQ-021 DivControl SHALL be ignored in RUN, FIX and DONE; operands SHALL be sampled only at the accepting IDLE edge (later DivA/DivB changes have no effect).
REQ-022 Back-to-back: DivControl high in the IDLE cycle directly after DONE SHALL be accepted normally.
REQ-023 DivZero SHALL be 0 whenever DivDone is 0.

Reset
REQ-024 Reset=0 SHALL force state IDLE, Hi=0, Lo=0, DivBusy=0, DivDone=0, DivZero=0, counter=0, asynchronously.
REQ-025 Reset asserted mid-RUN or mid-FIX SHALL abort the operation with no DivDone pulse and no Hi/Lo update beyond reset values.
REQ-026 After Reset deasserts, the first accepted DivControl SHALL behave as REQ-013/REQ-014.

Verification
REQ-027 DivA=7, DivB=2, start at edge T -> DivBusy high T+1..T+33, Lo=3, Hi=1 after T+33, DivDone=1 one cycle after T+34, DivZero=0.
REQ-028 DivA=-7 (0xFFFFFFF9), DivB=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DivA=7, DivB=-2 -> Lo=0xFFFFFFFD, Hi=1.
REQ-029 DivA=5, DivB=0, prior Hi=0x11, Lo=0x22 -> DivDone=DivZero=1 for one cycle after T+1, Hi=0x11, Lo=0x22 unchanged, DivBusy never high.
REQ-030 DivA=0x80000000, DivB=0xFFFFFFFF -> Lo=0x80000000, Hi=0; DivA=0x80000000, DivB=2 -> Lo=0xC0000000, Hi=0.
REQ-031 Start 100/7, pulse DivControl with 9/3 at T+10 and change DivA/DivB mid-RUN -> result Lo=14, Hi=2, single DivDone; then 9/3 started in the IDLE cycle after DONE -> Lo=3, Hi=0.
REQ-032 Start 100/7, drive Reset=0 at T+15 (between edges) -> outputs zero immediately, no DivDone; after release, 20/6 -> Lo=3, Hi=2 with normal timing.
